// File: rtl/seq_divider_pkg.sv
// ============================================================================
// seq_divider_pkg : shared FSM state encoding and default operand width.
// Revision 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_e;

endpackage : seq_divider_pkg

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// div_step : one combinational restoring shift-subtract iteration.
// Revision 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  // rem_i < divisor_i always holds, so the shifted value needs only one extra
  // bit and any successful difference fits back into WIDTH bits.
  assign w_shifted = {rem_i, bit_i};
  assign w_diff    = w_shifted[WIDTH-1:0] - divisor_i;
  assign qbit_o    = (w_shifted >= {1'b0, divisor_i});
  assign rem_o     = qbit_o ? w_diff : w_shifted[WIDTH-1:0];

endmodule : div_step

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : sequential restoring divider, signed/unsigned, one bit/cycle.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sign_mode_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;

  assign w_neg_a = sign_mode_i & dividend_i[WIDTH-1];
  assign w_neg_b = sign_mode_i & divisor_i[WIDTH-1];
  assign w_mag_a = w_neg_a ? -dividend_i : dividend_i;
  assign w_mag_b = w_neg_b ? -divisor_i  : divisor_i;

  // dvd_q doubles as the dividend shift register and the quotient collector.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (w_step_rem),
    .qbit_o    (w_step_qbit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dz_d    = (divisor_i == '0);
          state_d = dz_d ? FINAL : RUN;
          cnt_d   = '0;
          rem_d   = '0;
          // A zero divisor must hand back the raw dividend, not its magnitude.
          dvd_d   = dz_d ? dividend_i : w_mag_a;
          dsr_d   = w_mag_b;
          negq_d  = w_neg_a ^ w_neg_b;
          negr_d  = w_neg_a;
        end
      end
      RUN: begin
        rem_d = w_step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], w_step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          quot_d = '1;
          remo_d = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = negq_q ? -dvd_q : dvd_q;
          remo_d = negr_q ? -rem_q : rem_q;
          dbz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = remo_q;
  assign div_by_zero_o = dbz_q;

endmodule : seq_divider

`default_nettype wire
